// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the camera configuration sequencer.
// Holds the FSM state encoding, the register-table entry record
// {last, reg_addr, data}, the delay-entry marker and the default
// SCCB/I2C device write address, plus small helpers on entries.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP    = 3'd0,
    ST_LOAD     = 3'd1,
    ST_START_LO = 3'd2,
    ST_WAIT_END = 3'd3,
    ST_CHECK    = 3'd4,
    ST_DELAY    = 3'd5,
    ST_DONE     = 3'd6,
    ST_FAIL     = 3'd7
  } cfg_state_e;

  localparam int          ENTRY_W          = 25;
  localparam int          CNT_W            = 16;
  localparam logic [15:0] DELAY_REG        = 16'hFFFF;
  localparam logic [7:0]  DEV_ADDR_DEFAULT = 8'h78;

  typedef struct packed {
    logic        last;
    logic [15:0] reg_addr;
    logic [7:0]  data;
  } cfg_entry_t;

  // A delay entry carries no bus transfer; its data field is a wait count.
  function automatic logic is_delay(input cfg_entry_t e);
    return (e.reg_addr == DELAY_REG);
  endfunction

  // Write word handed to i2c_com: device address, 16-bit register, data.
  function automatic logic [31:0] make_word(input logic [7:0] dev, input cfg_entry_t e);
    return {dev, e.reg_addr, e.data};
  endfunction

endpackage

// File: rtl/cam_reg_lut.sv
// Camera register table as a combinational ROM.
// Ports:
//   addr   in  IDX_W  table index
//   entry  out 25     {last, reg_addr[15:0], data[7:0]}
// Unused indices return a zero-length delay marked last, so a stray
// index terminates the walk cleanly instead of writing garbage.
module cam_reg_lut
  import cam_cfg_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic [IDX_W-1:0] addr,
  output cfg_entry_t       entry
);

  // Table contents: soft reset, 5 ms settle, then two register writes.
  always_comb begin
    entry = {1'b1, DELAY_REG, 8'h00};
    case (addr)
      IDX_W'(0): entry = {1'b0, 16'h3008, 8'h82};
      IDX_W'(1): entry = {1'b0, DELAY_REG, 8'h05};
      IDX_W'(2): entry = {1'b0, 16'h3103, 8'h03};
      IDX_W'(3): entry = {1'b1, 16'h3017, 8'hFF};
      default:   entry = {1'b1, DELAY_REG, 8'h00};
    endcase
  end

endmodule

// File: rtl/i2c_cfg_seq.sv
// Upstream sequencer for the camera SCCB/I2C write engine (i2c_com).
// After a power-up wait it walks cam_reg_lut, issuing one 32-bit write
// per entry with a start/tr_end handshake, retrying NAKed or timed-out
// writes, and reporting cfg_done or cfg_err.
// Ports:
//   clock_i2c    in   I2C bit clock, all logic on its rising edge
//   camera_rstn  in   asynchronous active-low reset
//   cfg_restart  in   synchronous pulse, reruns the table from index 0
//   ack          in   0 = all bytes ACKed, valid with tr_end
//   tr_end       in   transfer finished, sticky until the next start
//   i2c_data     out  write word, only changes in LOAD
//   start        out  0 = hold engine idle/clear, 1 = run one transfer
//   cfg_done     out  every entry written
//   cfg_err      out  an entry failed after all retries
//   cfg_index    out  current or failing entry index
module i2c_cfg_seq
  import cam_cfg_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int         LUT_DEPTH   = 256,
  parameter int         PWRUP_CYC   = 400,
  parameter int         MAX_RETRY   = 3,
  parameter int         TIMEOUT_CYC = 63,
  parameter int         DLY_UNIT    = 20
) (
  input  logic        clock_i2c,
  input  logic        camera_rstn,
  input  logic        cfg_restart,
  input  logic        ack,
  input  logic        tr_end,
  output logic [31:0] i2c_data,
  output logic        start,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [7:0]  cfg_index
);

  localparam int IDX_W = $clog2(LUT_DEPTH);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic             nak_q, nak_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  cfg_entry_t       lut_entry;
  logic             last_s;
  cfg_state_e       adv_state_s;
  logic [IDX_W-1:0] adv_idx_s;

  cam_reg_lut #(.IDX_W(IDX_W)) u_lut (
    .addr  (idx_q),
    .entry (lut_entry)
  );

  // The top index is always treated as last so the walk never wraps silently.
  assign last_s      = lut_entry.last | (idx_q == IDX_W'(LUT_DEPTH - 1));
  assign adv_state_s = last_s ? ST_DONE : ST_LOAD;
  assign adv_idx_s   = last_s ? idx_q : (idx_q + IDX_W'(1));

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    data_d  = data_q;
    nak_d   = nak_q;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        if (is_delay(lut_entry)) begin
          if (lut_entry.data == 8'h00) begin
            state_d = adv_state_s;
            idx_d   = adv_idx_s;
          end else begin
            // Loaded with N-1 so DELAY occupies exactly data*DLY_UNIT cycles.
            cnt_d   = CNT_W'(int'(lut_entry.data) * DLY_UNIT - 1);
            state_d = ST_DELAY;
          end
        end else begin
          data_d  = make_word(DEV_ADDR, lut_entry);
          retry_d = '0;
          cnt_d   = '0;
          state_d = ST_START_LO;
        end
      end
      ST_START_LO: begin
        // Two low cycles let i2c_com clear tr_end/ack; tr_end is not looked at.
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT_END;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_END: begin
        // ack is only valid alongside tr_end, so the verdict is latched here.
        if (tr_end) begin
          nak_d   = ack;
          state_d = ST_CHECK;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          nak_d   = 1'b1;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (!nak_q) begin
          state_d = adv_state_s;
          idx_d   = adv_idx_s;
        end else if (retry_q < RTY_W'(MAX_RETRY)) begin
          retry_d = retry_q + RTY_W'(1);
          cnt_d   = '0;
          state_d = ST_START_LO;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          state_d = adv_state_s;
          idx_d   = adv_idx_s;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_FAIL: state_d = ST_FAIL;
      default: begin
        cnt_d   = '0;
        state_d = ST_PWRUP;
      end
    endcase

    // Restart overrides any decision taken above, including one in CHECK.
    if (cfg_restart) begin
      state_d = ST_LOAD;
      idx_d   = '0;
      cnt_d   = '0;
      retry_d = '0;
      nak_d   = 1'b0;
    end else begin
      nak_d = nak_d;
    end

    start_d = (state_d == ST_WAIT_END);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_FAIL);
  end

  // State and output registers.
  always_ff @(posedge clock_i2c or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state_q <= ST_PWRUP;
      cnt_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      data_q  <= 32'h0000_0000;
      nak_q   <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      nak_q   <= nak_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign i2c_data  = data_q;
  assign start     = start_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign cfg_index = 8'(idx_q);

endmodule
